// File: rtl/regbank4_2r1w.sv
// Four-entry register bank with one synchronous write port and two
// combinational read ports; entry 3 can be built as a constant-zero register.
module regbank4_2r1w #(
  parameter int WIDTH         = 64,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [1:0]       WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [1:0]       ReadReg1,
  input  logic [1:0]       ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [3:0][WIDTH-1:0] entry_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
      if (HARDWIRE_ZERO != 0 && gi == 3) begin : g_zero
        // No storage: writes to this index have nowhere to land.
        assign entry_q[gi] = '0;
      end else begin : g_store
        logic             wr_en;
        logic [WIDTH-1:0] q_reg;

        // Reset masks the enable so a write in a reset cycle is fully discarded.
        assign wr_en = RegWrite & ~reset & (WriteReg == 2'(gi));

        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= '0;
          end else if (wr_en) begin
            q_reg <= WriteData;
          end
        end

        assign entry_q[gi] = q_reg;
      end
    end
  endgenerate

  // Read ports select straight from the stored entries: no bypass of the
  // data being written this cycle.
  assign ReadData1 = entry_q[ReadReg1];
  assign ReadData2 = entry_q[ReadReg2];

endmodule

// File: tb/tb_regbank4_2r1w.sv
// Self-checking bench: two banks (zero register on/off) driven in parallel,
// compared every cycle against an array model plus directed literal checks.
module tb_regbank4_2r1w;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         RegWrite = 1'b0;
  logic [1:0]   WriteReg = 2'd0;
  logic [W-1:0] WriteData = '0;
  logic [1:0]   ReadReg1 = 2'd3;
  logic [1:0]   ReadReg2 = 2'd3;
  logic [W-1:0] rd1_hz, rd2_hz, rd1_nz, rd2_nz;

  int checks = 0;
  int failures = 0;

  // Reference: plain array of four values; zero-register variant masks index 3 on read.
  logic [W-1:0] mem [4];
  bit           mem_valid = 1'b0;

  regbank4_2r1w #(.WIDTH(W), .HARDWIRE_ZERO(1)) u_hz (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_hz), .ReadData2(rd2_hz)
  );

  regbank4_2r1w #(.WIDTH(W), .HARDWIRE_ZERO(0)) u_nz (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_nz), .ReadData2(rd2_nz)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_hz(input logic [1:0] idx);
    return (idx == 2'd3) ? '0 : mem[idx];
  endfunction

  function automatic logic [W-1:0] exp_nz(input logic [1:0] idx);
    return mem[idx];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Model update on each capturing edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      mem_valid = 1'b1;
    end else if (RegWrite) begin
      mem[WriteReg] = WriteData;
    end
  end

  // Compare process: away from the active edge, every cycle.
  always @(negedge clk) begin
    if (mem_valid) begin
      chk("cmp_hz_rd1", rd1_hz, exp_hz(ReadReg1));
      chk("cmp_hz_rd2", rd2_hz, exp_hz(ReadReg2));
      chk("cmp_nz_rd1", rd1_nz, exp_nz(ReadReg1));
      chk("cmp_nz_rd2", rd2_nz, exp_nz(ReadReg2));
    end else begin
      if (ReadReg1 == 2'd3) chk("cmp_hz_rd1_prereset", rd1_hz, '0);
      if (ReadReg2 == 2'd3) chk("cmp_hz_rd2_prereset", rd2_hz, '0);
    end
  end

  // One edge with the given controls; strobes are dropped right after the edge.
  task automatic cycle(input logic rst, input logic we, input logic [1:0] wr,
                       input logic [W-1:0] wd, input logic [1:0] r1, input logic [1:0] r2);
    reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2;
    @(posedge clk);
    #1;
    reset = 1'b0; RegWrite = 1'b0;
  endtask

  task automatic peek(input logic [1:0] r1, input logic [1:0] r2);
    ReadReg1 = r1; ReadReg2 = r2;
    #1;
  endtask

  initial begin
    // Zero register reads 0 even before any reset.
    #2;
    chk("prereset_hz_rd1", rd1_hz, '0);
    chk("prereset_hz_rd2", rd2_hz, '0);

    cycle(1'b1, 1'b0, 2'd0, '0, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), 2'(3 - i));
      chk("reset_hz_rd1", rd1_hz, '0);
      chk("reset_hz_rd2", rd2_hz, '0);
      chk("reset_nz_rd1", rd1_nz, '0);
      chk("reset_nz_rd2", rd2_nz, '0);
    end

    cycle(1'b0, 1'b1, 2'd0, 64'hDEAD_BEEF_0123_4567, 2'd0, 2'd1);
    cycle(1'b0, 1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 2'd1);
    peek(2'd0, 2'd1);
    chk("wr_rd_hz_rd1", rd1_hz, 64'hDEAD_BEEF_0123_4567);
    chk("wr_rd_hz_rd2", rd2_hz, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_rd_nz_rd1", rd1_nz, 64'hDEAD_BEEF_0123_4567);
    chk("wr_rd_nz_rd2", rd2_nz, 64'hFFFF_FFFF_FFFF_FFFF);

    // Same-cycle read of the entry being written: old before edge, new after.
    cycle(1'b0, 1'b1, 2'd2, 64'h5, 2'd2, 2'd2);
    reset = 1'b0; RegWrite = 1'b1; WriteReg = 2'd2; WriteData = 64'hA; ReadReg1 = 2'd2;
    #1;
    chk("bypass_before_edge", rd1_hz, 64'h5);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("bypass_after_edge", rd1_hz, 64'hA);

    cycle(1'b0, 1'b0, 2'd0, 64'h1234, 2'd0, 2'd2);
    peek(2'd0, 2'd2);
    chk("we_low_entry0", rd1_nz, 64'hDEAD_BEEF_0123_4567);
    chk("we_low_entry2", rd2_nz, 64'hA);

    cycle(1'b0, 1'b1, 2'd3, 64'hCAFE, 2'd3, 2'd3);
    peek(2'd3, 2'd3);
    chk("zero_hz_rd1", rd1_hz, '0);
    chk("zero_hz_rd2", rd2_hz, '0);
    chk("zero_nz_rd1", rd1_nz, 64'hCAFE);
    chk("zero_nz_rd2", rd2_nz, 64'hCAFE);

    cycle(1'b1, 1'b1, 2'd1, 64'h77, 2'd1, 2'd1);
    peek(2'd1, 2'd3);
    chk("rst_vs_wr_entry1", rd1_nz, '0);
    chk("rst_vs_wr_entry3", rd2_nz, '0);
    cycle(1'b0, 1'b1, 2'd1, 64'h77, 2'd1, 2'd1);
    peek(2'd1, 2'd1);
    chk("wr_after_rst_hz", rd1_hz, 64'h77);
    chk("wr_after_rst_nz", rd2_nz, 64'h77);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] d;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) d = '1;
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), d,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
